// File: rtl/rsa_pkg.sv
// Shared constants and SPI slave FSM encoding for the RSA configuration front end.
package rsa_pkg;

  localparam int SPI_CMD_W     = 8;
  localparam int ADDR_W        = 7;
  localparam int CMD_WRITE_BIT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, followed by a registered
// copy used to flag rising and falling edges in the clk domain.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, dly_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
      dly_p2  <= RST_VAL;
    end else begin
      sync_p0 <= din;
      // synchronised level
      sync_p1 <= sync_p0;
      // one-clk delayed copy for edge detection
      dly_p2  <= sync_p1;
    end
  end

  assign sync = sync_p1;
  assign rise = sync_p1 & ~dly_p2;
  assign fall = ~sync_p1 & dly_p2;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave exposing NUM_REGS R/W configuration registers plus a
// read-only status word, with burst access and address auto-increment.
module spi_reg_bank
  import rsa_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_cs_n,
  input  logic                       spi_clk,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  input  logic [DATA_W-1:0]          status_in,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_REGS);
  localparam logic [5:0]        CMD_LAST    = 6'(SPI_CMD_W - 1);
  localparam logic [5:0]        WORD_LAST   = 6'(DATA_W - 1);

  logic cs_sync, cs_rise, cs_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_p0, mosi_p1;

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi_clk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      mosi_p0 <= spi_mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  spi_state_e        state, state_nxt;
  logic              cmd_phase, data_phase;
  logic [5:0]        bit_cnt;
  logic              wr_mode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rx_shift, tx_shift, rx_word, rd_word;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              cmd_done, word_done;

  assign rx_word   = {rx_shift[DATA_W-2:0], mosi_p1};
  assign cmd_done  = cmd_phase  & sclk_rise & (bit_cnt == CMD_LAST);
  assign word_done = data_phase & sclk_rise & (bit_cnt == WORD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // cs_n high always wins, so an abort drops back to IDLE from any state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = CMD;
      CMD:     if (cs_sync) state_nxt = IDLE;
               else if (cmd_done) state_nxt = DATA;
      DATA:    if (cs_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_phase  = (state == CMD);
    data_phase = (state == DATA);
  end

  always_comb begin
    rd_word = '0;
    if (addr == STATUS_ADDR) rd_word = status_in;
    for (int k = 0; k < NUM_REGS; k++)
      if (addr == ADDR_W'(k)) rd_word = regs[k];
  end

  // Data shift register needs no reset: bit_cnt guarantees a full refill per word
  always_ff @(posedge clk) begin
    if ((cmd_phase || data_phase) && sclk_rise) rx_shift <= {rx_shift[DATA_W-2:0], mosi_p1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      wr_mode  <= 1'b0;
      addr     <= '0;
      tx_shift <= '0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
    end else begin
      wr_pulse <= 1'b0;
      if (state_nxt != state || word_done) bit_cnt <= '0;
      else if (sclk_rise)                  bit_cnt <= bit_cnt + 6'd1;

      if (cmd_done) begin
        wr_mode  <= rx_word[CMD_WRITE_BIT];
        addr     <= rx_word[ADDR_W-1:0];
        tx_shift <= '0;
      end

      // A word completing in the same clk as cs_n rising is still committed
      if (word_done) begin
        addr <= addr + ADDR_W'(1);
        if (wr_mode && addr < STATUS_ADDR) begin
          for (int k = 0; k < NUM_REGS; k++)
            if (addr == ADDR_W'(k)) regs[k] <= rx_word;
          wr_pulse <= 1'b1;
          wr_addr  <= addr;
        end
      end

      if (data_phase && sclk_fall) begin
        if (bit_cnt == 6'd0) tx_shift <= rd_word;
        else                 tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign spi_miso = data_phase & tx_shift[DATA_W-1];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_out[k*DATA_W +: DATA_W] = regs[k];
  end

endmodule
